number_hit_manager: RTL and testbench

NUMBER_HIT_MANAGER -- requirements
Module: number_hit_manager

---
 rtl/number_hit_manager.sv | 137 +++++++++++++
 tb/tb_number_hit_manager.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/number_hit_manager.sv
// number_hit_manager
// Detects player/digit collisions once per frame, emits one-cycle hit
// pulses, reloads hit digits with pseudo-random values (1..9) at the next
// frame start, and optionally accumulates a saturating score.
//
// Build option: define HIT_SCORE_EN to include the score accumulator.
// Without it the score output is tied to zero and no adder is built.
//
// Handshake note: there is no valid/ready flow here. startOfFrame is a
// one-cycle strobe, singleHit is a registered one-cycle pulse, and the
// score reflects a pulse on the clock edge that ends the pulse cycle.
module number_hit_manager #(
    parameter int NUMBERS   = 3,
    parameter int SCORE_MAX = 9999
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    playerDR,
    input  logic [NUMBERS-1:0]      numbersDR,
    input  logic [NUMBERS-1:0]      showNum,
    output logic [NUMBERS-1:0]      singleHit,
    output logic [NUMBERS-1:0][3:0] numbersToShow,
    output logic [13:0]             score,
    output logic                    fsmState
);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [NUMBERS-1:0] hitLatched;
    logic [NUMBERS-1:0] reloadPending;
    logic [NUMBERS-1:0] rawHit;
    logic [NUMBERS-1:0] newHit;
    logic [7:0]         lfsr;

    // Debug view of the FSM: 0 = waiting for first frame, 1 = active.
    assign fsmState = state;

    // Slot value after reset: 1,2,...,9,1,2,... so it is always a legal digit.
    function automatic logic [3:0] initValue(input int slot);
        return 4'((slot % 9) + 1);
    endfunction

    // Slot i reads four LFSR bits starting at bit i, wrapping past bit 7,
    // then folds the nibble into 1..9.
    function automatic logic [3:0] reloadValue(input logic [7:0] lf, input int slot);
        logic [3:0] nib;
        logic [2:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx    = 3'((slot + k) % 8);
            nib[k] = lf[idx];
        end
        return (nib % 4'd9) + 4'd1;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else       state <= nextState;
    end

    // FSM next state: leave WAIT_SOF on the first frame strobe, then stay.
    always_comb begin
        nextState = state;
        if (state == WAIT_SOF && startOfFrame) nextState = ACTIVE;
    end

    // Collision detect; a frame strobe masks any collision in the same cycle.
    always_comb begin
        rawHit = '0;
        if (state == ACTIVE && !startOfFrame)
            rawHit = numbersDR & showNum & {NUMBERS{playerDR}};
        newHit = rawHit & ~hitLatched;
    end

    // Per-frame hit latch, pulse register and reload bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            hitLatched    <= '0;
            singleHit     <= '0;
            reloadPending <= '0;
        end else if (startOfFrame) begin
            hitLatched    <= '0;
            singleHit     <= '0;
            reloadPending <= '0;
        end else begin
            hitLatched    <= hitLatched | rawHit;
            singleHit     <= newHit;
            reloadPending <= reloadPending | newHit;
        end
    end

    // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; seeded non-zero so it never locks.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Digit values hold during a frame; hit digits change only at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUMBERS; i++) numbersToShow[i] <= initValue(i);
        end else if (startOfFrame) begin
            for (int i = 0; i < NUMBERS; i++)
                if (reloadPending[i]) numbersToShow[i] <= reloadValue(lfsr, i);
        end
    end

`ifdef HIT_SCORE_EN
    logic [31:0] hitSum;
    logic [31:0] scoreNext;
    logic [13:0] scoreSat;

    // Sum the values of all digits pulsing this cycle and clamp at the ceiling.
    always_comb begin
        hitSum = '0;
        for (int i = 0; i < NUMBERS; i++)
            if (singleHit[i]) hitSum = hitSum + 32'(numbersToShow[i]);
        scoreNext = 32'(score) + hitSum;
        scoreSat  = (scoreNext > 32'(SCORE_MAX)) ? 14'(SCORE_MAX) : scoreNext[13:0];
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (reset) score <= '0;
        else       score <= scoreSat;
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_number_hit_manager.sv
// Testbench for number_hit_manager: a directed vector table, hand-written
// multi-cycle sequences, random traffic, and a cycle-level reference model
// whose predictions queue up and are compared one per clock.
module tb_number_hit_manager;

  localparam int N    = 3;
  localparam int SMAX = 9999;
`ifdef HIT_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sof = 1'b0;
  logic            pdr = 1'b0;
  logic [N-1:0]    ndr = '0;
  logic [N-1:0]    show = '0;
  logic [N-1:0]    single_hit;
  logic [N-1:0][3:0] nums;
  logic [13:0]     score;
  logic            fsm_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_active;
  bit [2:0] m_lat, m_pend, m_hit;
  int       m_num[3];
  int       m_score;
  int       m_lfsr;
  logic [28:0] exp_q[$];

  number_hit_manager #(.NUMBERS(N), .SCORE_MAX(SMAX)) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(sof),
    .playerDR(pdr),
    .numbersDR(ndr),
    .showNum(show),
    .singleHit(single_hit),
    .numbersToShow(nums),
    .score(score),
    .fsmState(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int reload_val(input int lf, input int slot);
    int rot;
    rot = ((lf >> slot) | (lf << (8 - slot))) & 'hF;
    return (rot % 9) + 1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_lat    = '0;
    m_pend   = '0;
    m_hit    = '0;
    m_score  = 0;
    m_lfsr   = 'hA5;
    for (int i = 0; i < 3; i++) m_num[i] = (i % 9) + 1;
  endtask

  // advance the model by one clock edge given the inputs seen at that edge
  task automatic model_edge(input bit r, input bit s, input bit p,
                            input bit [2:0] nd, input bit [2:0] sh);
    bit [2:0] raw;
    bit [2:0] nh;
    int       sum;
    int       fb;
    if (r) begin
      model_reset();
    end else begin
      raw = (m_active && !s) ? (nd & sh & {3{p}}) : 3'b000;
      nh  = raw & ~m_lat;
      sum = 0;
      for (int i = 0; i < 3; i++) if (m_hit[i]) sum += m_num[i];
      if (SCORE_ON) m_score = (m_score + sum > SMAX) ? SMAX : m_score + sum;
      for (int i = 0; i < 3; i++)
        if (s && m_pend[i]) m_num[i] = reload_val(m_lfsr, i);
      m_pend = s ? 3'b000 : (m_pend | nh);
      m_lat  = s ? 3'b000 : (m_lat | raw);
      m_hit  = s ? 3'b000 : nh;
      if (s) m_active = 1'b1;
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) & 'hFF) | fb;
    end
    exp_q.push_back({m_hit, 4'(m_num[2]), 4'(m_num[1]), 4'(m_num[0]), 14'(m_score)});
  endtask

  // pop the oldest prediction and compare against the DUT outputs
  task automatic sb_check();
    logic [28:0] e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("singleHit", 32'(single_hit), 32'(e[28:26]));
      chk("numbersToShow", 32'(nums), 32'(e[25:14]));
      chk("score", 32'(score), 32'(e[13:0]));
    end
  endtask

  // driver: apply inputs for one cycle, predict, then compare at negedge
  task automatic step(input bit r, input bit s, input bit p,
                      input bit [2:0] nd, input bit [2:0] sh);
    reset = r; sof = s; pdr = p; ndr = nd; show = sh;
    @(posedge clk);
    model_edge(r, s, p, nd, sh);
    @(negedge clk);
    sb_check();
  endtask

  typedef struct {
    bit       sof;
    bit       pdr;
    bit [2:0] ndr;
    bit [2:0] show;
    int       reps;
    bit [2:0] exp_first;
    int       exp_score;
    int       exp_n0;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n0_saved;
    int frames;

    // reset state
    step(1, 0, 0, 3'b000, 3'b000);
    chk("rst_singleHit", 32'(single_hit), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_nums", 32'(nums), 32'h321);
    chk("rst_fsm", 32'(fsm_state), 0);

    // directed table: {sof, pdr, ndr, show, reps, first-cycle hit, last-cycle score, digit0 or -1}
    vecs[0] = '{1'b0, 1'b1, 3'b010, 3'b111, 2,  3'b000, 0, 1};   // collision before first SOF
    vecs[1] = '{1'b1, 1'b1, 3'b010, 3'b111, 1,  3'b000, 0, 1};   // collision on activating SOF
    vecs[2] = '{1'b0, 1'b1, 3'b010, 3'b111, 10, 3'b010, 2, 1};   // 10-cycle overlap, one pulse
    vecs[3] = '{1'b1, 1'b1, 3'b101, 3'b111, 1,  3'b000, 2, 1};   // collision coincident with SOF
    vecs[4] = '{1'b0, 1'b1, 3'b101, 3'b111, 3,  3'b101, 6, 1};   // digits 0 and 2 together
    vecs[5] = '{1'b0, 1'b1, 3'b001, 3'b111, 2,  3'b000, 6, 1};   // repeat in same frame ignored
    vecs[6] = '{1'b1, 1'b0, 3'b000, 3'b111, 1,  3'b000, 6, -1};  // reload frame
    vecs[7] = '{1'b0, 1'b1, 3'b010, 3'b101, 3,  3'b000, 6, -1};  // hidden digit 1 not hit

    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(0, vecs[v].sof, vecs[v].pdr, vecs[v].ndr, vecs[v].show);
        chk($sformatf("vec%0d_hit", v), 32'(single_hit),
            (r == 0) ? 32'(vecs[v].exp_first) : 0);
        if (r == vecs[v].reps - 1) begin
          chk($sformatf("vec%0d_score", v), 32'(score), SCORE_ON ? vecs[v].exp_score : 0);
          if (vecs[v].exp_n0 >= 0)
            chk($sformatf("vec%0d_num0", v), 32'(nums[0]), vecs[v].exp_n0);
        end
      end
    end
    chk("fsm_active", 32'(fsm_state), 1);

    // reloaded digit is legal, and a SOF without a hit leaves it alone
    chk("num0_range", (nums[0] >= 4'd1 && nums[0] <= 4'd9) ? 1 : 0, 1);
    n0_saved = m_num[0];
    step(0, 1, 0, 3'b000, 3'b111);
    step(0, 0, 0, 3'b000, 3'b111);
    chk("num0_hold", 32'(nums[0]), n0_saved);

    // reset one cycle after a hit aborts the score update and reload
    step(0, 0, 1, 3'b100, 3'b111);
    chk("pre_rst_hit", 32'(single_hit), 32'b100);
    step(1, 0, 0, 3'b000, 3'b000);
    chk("mid_rst_hit", 32'(single_hit), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_nums", 32'(nums), 32'h321);
    step(0, 0, 0, 3'b000, 3'b000);

    // random traffic with a frame strobe every 8 cycles
    for (int c = 0; c < 300; c++)
      step(0, (c % 8) == 0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // saturation: hit every digit each frame until the ceiling is reached
    step(1, 0, 0, 3'b000, 3'b000);
    frames = 0;
    while (frames < 1000) begin
      step(0, 1, 0, 3'b000, 3'b111);
      step(0, 0, 1, 3'b111, 3'b111);
      step(0, 0, 0, 3'b000, 3'b111);
      step(0, 0, 0, 3'b000, 3'b111);
      frames++;
      if (SCORE_ON && m_score == SMAX) break;
      if (!SCORE_ON && frames == 30) break;
    end
    chk("score_sat", 32'(score), SCORE_ON ? SMAX : 0);
    step(0, 1, 0, 3'b000, 3'b111);
    step(0, 0, 1, 3'b111, 3'b111);
    step(0, 0, 0, 3'b000, 3'b111);
    step(0, 0, 0, 3'b000, 3'b111);
    chk("score_no_wrap", 32'(score), SCORE_ON ? SMAX : 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
